// File: rtl/count_sequencer.sv
// Run/pause/clear controller for the display counter.
// A prescaler paces an up/down counter; the tick output is a one-cycle enable.
module count_sequencer #(
    parameter int TICK_DIV = 100_000_000,
    parameter int MAX_VAL  = 9999,
    parameter int CW       = 14,
    parameter int WRAP     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          up_dn,
    output logic [CW-1:0] count,
    output logic          tick,
    output logic          running,
    output logic          done,
    output logic [1:0]    state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] TOP = CW'(MAX_VAL);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t st;
    logic [PW-1:0] pre;

    logic          step;
    logic          term;
    logic          load_ok;
    logic [CW-1:0] nxt;
    logic [CW-1:0] ldv;

    assign step    = (st == RUN) && (pre == PRE_LAST);
    assign term    = up_dn ? (count == TOP) : (count == '0);
    assign load_ok = load && ((st == IDLE) || (st == PAUSE));
    assign ldv     = (load_val > TOP) ? TOP : load_val;

    // At the terminal value either wrap to the opposite end or hold.
    always_comb begin
        nxt = count;
        if (term) begin
            if (WRAP != 0) nxt = up_dn ? '0 : TOP;
        end else begin
            nxt = up_dn ? count + CW'(1) : count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= IDLE;
            count <= '0;
            pre   <= '0;
            tick  <= 1'b0;
        end else if (clear) begin
            st    <= IDLE;
            count <= '0;
            pre   <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (load_ok) begin
                count <= ldv;
            end else begin
                unique case (st)
                    IDLE: begin
                        pre <= '0;
                        if (start) st <= RUN;
                    end
                    RUN: begin
                        if (step) begin
                            pre   <= '0;
                            tick  <= 1'b1;
                            count <= nxt;
                            if (term && (WRAP == 0)) st <= DONE;
                            else if (stop)           st <= PAUSE;
                        end else begin
                            pre <= pre + PW'(1);
                            if (stop) st <= PAUSE;
                        end
                    end
                    PAUSE: begin
                        if (start) st <= RUN;
                    end
                    DONE: begin
                        pre <= '0;
                    end
                endcase
            end
        end
    end

    assign state   = st;
    assign running = (st == RUN);
    assign done    = (st == DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: a wrapping and a non-wrapping instance share stimulus;
// expected tick events are queued and checked by per-instance monitors.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, clear, load, up_dn;
    logic [3:0] load_val;

    logic [3:0] count_a, count_b;
    logic       tick_a, tick_b;
    logic       running_a, running_b;
    logic       done_a, done_b;
    logic [1:0] state_a, state_b;

    int cyc = 0;
    int vecs = 0;
    int errs = 0;

    typedef struct {
        int         c;
        logic [3:0] n;
        logic [1:0] s;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];

    count_sequencer #(.TICK_DIV(4), .MAX_VAL(9), .CW(4), .WRAP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .load(load), .load_val(load_val), .up_dn(up_dn),
        .count(count_a), .tick(tick_a), .running(running_a),
        .done(done_a), .state(state_a)
    );

    count_sequencer #(.TICK_DIV(4), .MAX_VAL(9), .CW(4), .WRAP(0)) dut_nw (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .load(load), .load_val(load_val), .up_dn(up_dn),
        .count(count_b), .tick(tick_b), .running(running_b),
        .done(done_b), .state(state_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input string nm, input ev_t e, input logic [3:0] n,
                       input logic [1:0] s);
        vecs++;
        if (e.c != cyc || e.n != n || e.s != s) begin
            errs++;
            $display("FAIL %s: got cyc=%0d count=%0d state=%0d expected cyc=%0d count=%0d state=%0d",
                     nm, cyc, n, s, e.c, e.n, e.s);
        end
    endtask

    always @(negedge clk) begin
        if (tick_a) begin
            if (qa.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL tick_a: unexpected tick at cyc=%0d count=%0d", cyc, count_a);
            end else begin
                mon("tick_a", qa.pop_front(), count_a, state_a);
            end
        end
    end

    always @(negedge clk) begin
        if (tick_b) begin
            if (qb.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL tick_b: unexpected tick at cyc=%0d count=%0d", cyc, count_b);
            end else begin
                mon("tick_b", qb.pop_front(), count_b, state_b);
            end
        end
    end

    task automatic wait_to(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic pulse(input logic st_, input logic sp_, input logic cl_, input logic ld_);
        start = st_;
        stop  = sp_;
        clear = cl_;
        load  = ld_;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        load  = 1'b0;
    endtask

    int s;
    int m;

    initial begin
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
        up_dn = 1'b1; load_val = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_count", count_a, 0);
        chk("rst_state", state_a, 0);
        chk("rst_tick", tick_a, 0);
        chk("rst_flags", {running_a, done_a}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", state_b, 0);

        // count to 5, then async reset mid-period
        s = cyc + 1;
        for (int k = 1; k <= 5; k++) begin
            qa.push_back('{s + 4 * k, 4'(k), 2'd1});
            qb.push_back('{s + 4 * k, 4'(k), 2'd1});
        end
        pulse(1, 0, 0, 0);
        wait_to(s + 22);
        chk("pre_rst_count", count_a, 5);
        rst = 1'b1;
        #1;
        chk("async_rst_count", count_a, 0);
        chk("async_rst_state", state_a, 0);
        chk("async_rst_running", running_a, 0);
        chk("async_rst_nw_count", count_b, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rel_state", state_a, 0);
        chk("rel_count", count_a, 0);

        // up through the terminal value: wrap vs DONE
        s = cyc + 1;
        for (int k = 1; k <= 9; k++) begin
            qa.push_back('{s + 4 * k, 4'(k), 2'd1});
            qb.push_back('{s + 4 * k, 4'(k), 2'd1});
        end
        qa.push_back('{s + 40, 4'd0, 2'd1});
        qb.push_back('{s + 40, 4'd9, 2'd3});
        qa.push_back('{s + 44, 4'd1, 2'd1});
        qa.push_back('{s + 48, 4'd2, 2'd1});
        pulse(1, 0, 0, 0);
        wait_to(s + 41);
        pulse(1, 0, 0, 0);
        chk("done_ignores_start", state_b, 3);
        chk("done_holds", count_b, 9);
        chk("done_flag", done_b, 1);
        chk("wrap_running", running_a, 1);
        wait_to(s + 49);
        pulse(0, 0, 1, 0);
        chk("clear_state_a", state_a, 0);
        chk("clear_count_a", count_a, 0);
        chk("clear_state_b", state_b, 0);
        chk("clear_count_b", count_b, 0);

        // down from 0, pause mid-period, resume, stop on a step edge
        up_dn = 1'b0;
        s = cyc + 1;
        qa.push_back('{s + 4, 4'd9, 2'd1});
        qb.push_back('{s + 4, 4'd0, 2'd3});
        pulse(1, 0, 0, 0);
        wait_to(s + 5);
        pulse(0, 1, 0, 0);
        chk("pause_state", state_a, 2);
        chk("pause_count", count_a, 9);
        wait_to(s + 10);
        chk("pause_hold", count_a, 9);
        m = cyc + 1;
        qa.push_back('{m + 2, 4'd8, 2'd1});
        qa.push_back('{m + 6, 4'd7, 2'd2});
        pulse(1, 0, 0, 0);
        wait_to(m + 5);
        pulse(0, 1, 0, 0);
        wait_to(m + 12);
        chk("stop_on_step_state", state_a, 2);
        chk("stop_on_step_count", count_a, 7);

        // load clamping and priority
        load_val = 4'd12;
        pulse(0, 0, 0, 1);
        chk("load_pause_clamp", count_a, 9);
        chk("load_done_ignored", count_b, 0);
        pulse(0, 0, 1, 0);
        pulse(0, 0, 0, 1);
        chk("load_idle_clamp", count_b, 9);
        chk("load_idle_state", state_b, 0);
        load_val = 4'd4;
        pulse(1, 0, 0, 1);
        chk("load_beats_start_cnt", count_a, 4);
        chk("load_beats_start_st", state_a, 0);

        up_dn = 1'b1;
        s = cyc + 1;
        qa.push_back('{s + 4, 4'd5, 2'd1});
        qb.push_back('{s + 4, 4'd5, 2'd1});
        pulse(1, 0, 0, 0);
        load_val = 4'd3;
        pulse(0, 0, 0, 1);
        wait_to(s + 5);
        chk("load_run_ignored", count_a, 5);
        load_val = 4'd2;
        pulse(0, 0, 1, 1);
        chk("clear_beats_load_cnt", count_a, 0);
        chk("clear_beats_load_st", state_b, 0);

        repeat (6) @(negedge clk);
        chk("queue_drain", qa.size() + qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
